// File: rtl/uart_rx.sv
// Purpose : 8N1 UART receiver, 2-flop synchronised line, one-entry output register.
// Latency : rx_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT clocks after the first low rx sample.
// Backpressure: none on the line; an unconsumed byte is overwritten and overrun is flagged.
//
// Ports:
//   clock     system clock, rising edge
//   n_rst     asynchronous active-low reset
//   rx        serial line, idle high, asynchronous to clock
//   rx_data   last received byte
//   rx_valid  rx_data holds an unconsumed byte
//   rx_ack    one-cycle consume strobe, honoured only while rx_valid=1
//   frame_err sticky: stop bit sampled low
//   overrun   sticky: byte completed while previous byte unconsumed
//   busy      receiver is not idle (combinational decode of state)

module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clock,
  input  logic       n_rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser: both flops reset high so reset never looks like a start edge.
  logic rx_meta;
  logic rx_s;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] clk_cnt, cnt_nxt;
  logic [2:0]       bit_idx, idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             deliver;
  logic             ferr_set;
  logic             ack_eff;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State and frame datapath registers.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= cnt_nxt;
      bit_idx <= idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Next-state and frame datapath decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = clk_cnt;
    idx_nxt   = bit_idx;
    shreg_nxt = shreg;
    deliver   = 1'b0;
    ferr_set  = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = S_START;
        end
      end

      // Re-check the line half a bit in; a short low pulse is dropped silently.
      S_START: begin
        if (clk_cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            idx_nxt   = '0;
          end
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end

      // Samples land mid-bit because START already consumed half a bit.
      S_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            deliver   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = S_BREAK;
          end
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end

      // Hold off until the line returns high so a break is not read as a new start.
      S_BREAK: begin
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // An ack with nothing held is ignored entirely.
  assign ack_eff = rx_ack & rx_valid;

  // Output register and sticky flags.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (deliver) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (ack_eff) begin
        rx_valid <= 1'b0;
      end

      // Ack on the delivery cycle consumes the old byte, so that is not an overrun.
      if (deliver && rx_valid && !rx_ack) begin
        overrun <= 1'b1;
      end else if (ack_eff) begin
        overrun <= 1'b0;
      end

      if (ferr_set) begin
        frame_err <= 1'b1;
      end else if (ack_eff) begin
        frame_err <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit-by-bit, expected bytes queued
// at send time and popped when the receiver presents a new byte.
module tb_uart_rx;

  localparam int CPB  = 434;
  localparam int HALF = 217;
  // Drive-to-first-visible-sample distance: 1 to the sampling edge, then 2 + HALF + 9*CPB.
  localparam int LAT  = 1 + 2 + HALF + 9 * CPB;

  logic       clock;
  logic       n_rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int cyc = 0;
  int total = 0;
  int passes = 0;
  int fails = 0;
  logic [7:0] sb_q[$];

  uart_rx #(.CLK_FREQ(50000000), .BAUD(115200)) dut (
    .clock    (clock),
    .n_rst    (n_rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame starting at the current negedge; stop_low holds the stop bit low
  // for that many bit times before releasing the line high for one bit time.
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      repeat (stop_low * CPB) @(negedge clock);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clock);
    rx_ack = 1'b0;
  endtask

  // Wait for a new byte (valid rising or held data replaced), compare against the
  // scoreboard, then optionally ack ack_dly clocks later (ack_dly < 0: no ack).
  task automatic expect_byte(input string tag, input int t0, input int ack_dly,
                             input logic exp_fe, input logic exp_ov);
    logic       pv;
    logic [7:0] pd;
    logic [7:0] exp_b;
    int         n;
    bit         hit;
    int         lat;
    pv  = rx_valid;
    pd  = rx_data;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < LAT + 1000) begin
      @(negedge clock);
      n++;
      if (rx_valid && (!pv || rx_data !== pd)) hit = 1'b1;
    end
    lat = cyc - t0;
    total++;
    assert (hit) passes++;
    else begin
      fails++;
      $error("FAIL %s_timeout: observed no delivery expected delivery within %0d clocks", tag, LAT + 1000);
    end
    if (sb_q.size() > 0) exp_b = sb_q.pop_front();
    else exp_b = 8'hxx;
    chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp_b});
    total++;
    assert (lat >= LAT - 2 && lat <= LAT + 2) passes++;
    else begin
      fails++;
      $error("FAIL %s_latency: observed %0d expected %0d +/-2", tag, lat, LAT);
    end
    chk({tag, "_ferr"}, {31'd0, frame_err}, {31'd0, exp_fe});
    chk({tag, "_ovr"}, {31'd0, overrun}, {31'd0, exp_ov});
    if (ack_dly >= 0) begin
      repeat (ack_dly) @(negedge clock);
      pulse_ack();
      chk({tag, "_ack_valid"}, {31'd0, rx_valid}, 32'd0);
      chk({tag, "_ack_ferr"}, {31'd0, frame_err}, 32'd0);
      chk({tag, "_ack_ovr"}, {31'd0, overrun}, 32'd0);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data"}, {24'd0, rx_data}, 32'd0);
    chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int t0;
    int busy_cnt;
    n_rst  = 1'b0;
    rx     = 1'b1;
    rx_ack = 1'b0;
    repeat (5) @(negedge clock);
    chk_outputs_zero("reset");
    n_rst = 1'b1;
    repeat (10) @(negedge clock);

    // Two back-to-back frames, each acked 10 clocks after delivery.
    sb_q.push_back(8'h55);
    t0 = cyc;
    fork
      send_frame(8'h55, 0);
      expect_byte("b55", t0, 10, 1'b0, 1'b0);
    join
    sb_q.push_back(8'hA3);
    t0 = cyc;
    fork
      send_frame(8'hA3, 0);
      expect_byte("bA3", t0, 10, 1'b0, 1'b0);
    join
    repeat (20) @(negedge clock);

    // 100-clock glitch: busy for exactly HALF clocks, then idle with no flags.
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clock);
      if (i == 100) rx = 1'b1;
      if (busy) busy_cnt++;
    end
    chk("glitch_busy_clocks", busy_cnt, HALF);
    chk("glitch_busy_end", {31'd0, busy}, 32'd0);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_ferr", {31'd0, frame_err}, 32'd0);
    chk("glitch_ovr", {31'd0, overrun}, 32'd0);

    // Framing error with a long low stop bit, then a clean frame.
    send_frame(8'h3C, 2);
    chk("ferr_set", {31'd0, frame_err}, 32'd1);
    chk("ferr_valid", {31'd0, rx_valid}, 32'd0);
    chk("ferr_no_restart", {31'd0, busy}, 32'd0);
    sb_q.push_back(8'h81);
    t0 = cyc;
    fork
      send_frame(8'h81, 0);
      expect_byte("b81", t0, 10, 1'b1, 1'b0);
    join
    repeat (20) @(negedge clock);

    // Overrun: first byte left unconsumed, second overwrites it.
    sb_q.push_back(8'h11);
    t0 = cyc;
    fork
      send_frame(8'h11, 0);
      expect_byte("b11", t0, -1, 1'b0, 1'b0);
    join
    sb_q.push_back(8'h22);
    t0 = cyc;
    fork
      send_frame(8'h22, 0);
      expect_byte("b22", t0, -1, 1'b0, 1'b1);
    join
    chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
    pulse_ack();
    chk("ovr_ack_valid", {31'd0, rx_valid}, 32'd0);
    chk("ovr_ack_ovr", {31'd0, overrun}, 32'd0);
    repeat (20) @(negedge clock);

    // Ack landing on the exact delivery edge of the second byte.
    sb_q.push_back(8'h5A);
    t0 = cyc;
    fork
      send_frame(8'h5A, 0);
      expect_byte("b5A", t0, -1, 1'b0, 1'b0);
    join
    sb_q.push_back(8'h7E);
    t0 = cyc;
    fork
      send_frame(8'h7E, 0);
      begin
        while (cyc < t0 + LAT - 1) @(negedge clock);
        pulse_ack();
      end
      expect_byte("b7E", t0, -1, 1'b0, 1'b0);
    join
    chk("ackdel_valid", {31'd0, rx_valid}, 32'd1);
    pulse_ack();
    chk("ackdel_clear", {31'd0, rx_valid}, 32'd0);
    repeat (20) @(negedge clock);

    // Reset during data bit 4 of 0xF0: frame discarded, next frame clean.
    fork
      send_frame(8'hF0, 0);
      begin
        repeat (5 * CPB + 200) @(negedge clock);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        n_rst = 1'b0;
        repeat (2) @(negedge clock);
        chk_outputs_zero("midrst");
        repeat (20) @(negedge clock);
        n_rst = 1'b1;
      end
    join
    chk("post_rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    sb_q.push_back(8'h0F);
    t0 = cyc;
    fork
      send_frame(8'h0F, 0);
      expect_byte("b0F", t0, 10, 1'b0, 1'b0);
    join
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of uart_tx.
- Deserialises the RxD line into bytes and holds each byte in a one-entry output register with a valid/ack handshake.
- Sits beside uart_tx in top. The memory-mapped glue raises rx_ack when the CPU consumes the byte.
- Runs on the single system clock; no PLL.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line bit rate
CLKS_PER_BIT, CLK_FREQ/BAUD (434), clocks per bit; derived, not overridden independently
HALF_BIT, CLKS_PER_BIT/2 (217), clocks from start-edge detection to start-bit mid-sample

Ports:
clock  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clock
rx_data  output  8  last received byte
rx_valid  output  1  rx_data holds an unconsumed byte
rx_ack  input  1  one-cycle consume strobe, valid only while rx_valid=1
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte completed while previous byte unconsumed
busy  output  1  state != IDLE

Behaviour:
- Reset (n_rst=0, asynchronous):
  - state=IDLE; counters, shift register and rx_data = 0.
  - rx_valid, frame_err, overrun = 0.
  - Both synchroniser flops = 1.
  - Reset mid-frame aborts the frame silently; nothing is delivered.
- Input path: rx passes through a 2-flop synchroniser (rx_s). Only rx_s is used internally.
- FSM states:
  - IDLE: rx_s=0 -> START, clk_cnt=0.
  - START: at clk_cnt=HALF_BIT-1, sample rx_s.
    - rx_s=1 -> IDLE (glitch rejected, no flags).
    - rx_s=0 -> DATA, clk_cnt=0, bit_idx=0.
  - DATA: at clk_cnt=CLKS_PER_BIT-1, shift rx_s in LSB-first (shreg <= {rx_s, shreg[7:1]}), clk_cnt=0, bit_idx++.
    - After bit_idx 7 is sampled -> STOP.
  - STOP: at clk_cnt=CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1: deliver the byte (below), -> IDLE.
    - rx_s=0: frame_err<=1, byte discarded, rx_valid and rx_data unchanged, -> BREAK.
  - BREAK: remain until rx_s=1, then -> IDLE. This prevents a low line or break from retriggering a start.
- Counters: clk_cnt is 9 bits (holds CLKS_PER_BIT-1); bit_idx is 3 bits. Neither counter wraps inside a frame.
- Delivery (registered; visible the cycle after the stop sample):
  - rx_data<=shreg, rx_valid<=1.
  - If rx_valid=1 and rx_ack=0 in that cycle, overrun<=1. The new byte overwrites the old one.
- Handshake:
  - rx_ack=1 with rx_valid=1 and no delivery in the same cycle: rx_valid<=0, frame_err<=0, overrun<=0.
  - rx_ack and delivery in the same cycle: new byte loaded, rx_valid stays 1, overrun not set. frame_err and overrun are still cleared by the ack.
  - rx_ack while rx_valid=0 is ignored; flags unchanged.
  - rx_data stays stable while rx_valid=1, except on overwrite.
- Latency: with the first low rx sampled at edge E, rx_valid rises at E + 2 + HALF_BIT + 9*CLKS_PER_BIT (nominal 4125 clocks). Bench tolerance is +/-2 clocks.
- Back-to-back frames: a start bit immediately after the stop bit is accepted. IDLE is re-entered before the next falling edge is seen.
- busy is a combinational decode of state. All other outputs are registered.

Test Plan:
- Send 0x55 then 0xA3 at 115200 baud (434 clk/bit), acking each 10 clocks after rx_valid -> rx_data=0x55 then 0xA3; rx_valid rises ~4125 clocks after each start edge; frame_err=0, overrun=0.
- 100-clock low glitch on idle rx -> returns to IDLE after 219 clocks; rx_valid, frame_err and overrun stay 0; busy pulses high.
- Frame 0x3C with stop bit held low for 2 bit times, then high -> frame_err=1, rx_valid=0, no spurious start during BREAK. The next frame 0x81 is delivered correctly. rx_ack clears frame_err.
- Send 0x11 (no ack), then 0x22 -> rx_data=0x22, rx_valid=1, overrun=1. One rx_ack -> rx_valid=0, overrun=0.
- rx_ack asserted on the exact delivery cycle of the second byte 0x7E -> rx_data=0x7E, rx_valid=1, overrun=0.
- Assert n_rst during data bit 4 of frame 0xF0, release, then send 0x0F -> no delivery of 0xF0; all outputs 0 during reset; 0x0F received cleanly.
